// File: rtl/gpio_bus_master_if.sv
// rtl/gpio_bus_master_if.sv - request/response handshake between the core and the GPIO bus master
interface gpio_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_sel;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_rdata;

    // Core-side requester
    modport master (
        output req_valid, req_write, req_sel, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    // Bus master accepting requests
    modport slave (
        input  req_valid, req_write, req_sel, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/gpio_bus_master.sv
// rtl/gpio_bus_master.sv - single-transaction initiator for the 8-bit address / 16-bit data GPIO bus (option: GPIO_MASTER_HOLD_EN)
module gpio_bus_master #(
    parameter logic [7:0]  ADDRESS_IN   = 8'h04,
    parameter logic [7:0]  ADDRESS_OUT  = 8'h05,
    parameter logic [7:0]  ADDRESS_DIR  = 8'h06,
    parameter int unsigned SETUP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    gpio_bus_master_if.slave  req_if,
    output logic [7:0]        addressbus,
    inout  wire  [15:0]       databus,
    output logic              Read_In,
    output logic              Load_Out,
    output logic              Load_DIR,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_t;

    localparam logic [1:0] SEL_IN  = 2'd0;
    localparam logic [1:0] SEL_OUT = 2'd1;
    localparam logic [1:0] SEL_DIR = 2'd2;

    // Counter reload value; SETUP_CYCLES is limited to 1..15 so it fits 4 bits
    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);

    generate
        if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
            $error("gpio_bus_master: SETUP_CYCLES must be in 1..15");
        end
    endgenerate

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  setup_cnt;
    logic        write_q;
    logic [1:0]  sel_q;
    logic [15:0] wdata_q;
    logic        err_q;
    logic [15:0] rdata_q;
    logic [7:0]  addr_dec;
    logic        accept;
    logic        legal;
    logic        bus_active;
    logic        drive_bus;

    // A request is taken only in IDLE; everything else ignores req_valid
    assign accept = (state == IDLE) && req_if.req_valid;

    // Only IN is readable and only OUT/DIR are writable
    assign legal = (!req_if.req_write && (req_if.req_sel == SEL_IN)) ||
                   ( req_if.req_write && ((req_if.req_sel == SEL_OUT) ||
                                          (req_if.req_sel == SEL_DIR)));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; illegal requests bypass the bus entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = legal ? SETUP : RESP;
                end
            end
            SETUP: begin
                if (setup_cnt == 4'd0) begin
                    state_nxt = STROBE;
                end
            end
            STROBE: begin
`ifdef GPIO_MASTER_HOLD_EN
                state_nxt = HOLD;
`else
                state_nxt = RESP;
`endif
            end
            HOLD:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address setup down-counter, reloaded on every accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            setup_cnt <= 4'd0;
        end else if (accept) begin
            setup_cnt <= SETUP_LOAD;
        end else if ((state == SETUP) && (setup_cnt != 4'd0)) begin
            setup_cnt <= setup_cnt - 4'd1;
        end
    end

    // Request capture so the core may change its inputs after the accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_q <= 1'b0;
            sel_q   <= 2'd0;
            wdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else if (accept) begin
            write_q <= req_if.req_write;
            sel_q   <= req_if.req_sel;
            wdata_q <= req_if.req_wdata;
            err_q   <= !legal;
        end
    end

    // Read data is sampled at the edge that closes the Read_In strobe and held until the next read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= 16'h0000;
        end else if ((state == STROBE) && !write_q) begin
            rdata_q <= databus;
        end
    end

    // Register select to bus address
    always_comb begin
        addr_dec = ADDRESS_IN;
        case (sel_q)
            SEL_OUT: addr_dec = ADDRESS_OUT;
            SEL_DIR: addr_dec = ADDRESS_DIR;
            default: addr_dec = ADDRESS_IN;
        endcase
    end

    // Bus side: address is parked at 0 outside the setup/strobe/hold window
    assign bus_active = (state == SETUP) || (state == STROBE) || (state == HOLD);
    assign addressbus = bus_active ? addr_dec : 8'h00;

    // Strobes are mutually exclusive by construction: each needs a distinct write_q/sel_q combination
    assign Read_In  = (state == STROBE) && !write_q;
    assign Load_Out = (state == STROBE) &&  write_q && (sel_q == SEL_OUT);
    assign Load_DIR = (state == STROBE) &&  write_q && (sel_q == SEL_DIR);

    // Data is driven only for writes, so the bus is always released while Read_In is high
    assign drive_bus = write_q && ((state == STROBE) || (state == HOLD));
    assign databus   = drive_bus ? wdata_q : 16'hzzzz;

    // Core side
    assign req_if.req_ready = (state == IDLE);
    assign req_if.rsp_valid = (state == RESP);
    assign req_if.rsp_err   = (state == RESP) && err_q;
    assign req_if.rsp_rdata = rdata_q;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_gpio_bus_master.sv
// tb/tb_gpio_bus_master.sv - directed self-checking bench for gpio_bus_master
module tb_gpio_bus_master;

`ifdef GPIO_MASTER_HOLD_EN
    localparam int HOLD_CYC = 1;
`else
    localparam int HOLD_CYC = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    gpio_bus_master_if ifc ();
    gpio_bus_master_if ifc3 ();

    wire  [15:0] bus;
    wire  [15:0] bus3;
    logic [7:0]  addr, addr3;
    logic        rd, lo, ld, busy1;
    logic        rd3, lo3, ld3, busy3;
    logic [15:0] io_pins;
    logic [15:0] r_out, r_dir, r_dir3;

    int n_chk  = 0;
    int n_fail = 0;
    int overlap = 0;
    int rsp_cnt = 0;

    gpio_bus_master #(.SETUP_CYCLES(1)) dut (
        .clk(clk), .reset(rst_n), .req_if(ifc),
        .addressbus(addr), .databus(bus),
        .Read_In(rd), .Load_Out(lo), .Load_DIR(ld), .busy(busy1)
    );

    gpio_bus_master #(.SETUP_CYCLES(3)) dut3 (
        .clk(clk), .reset(rst_n), .req_if(ifc3),
        .addressbus(addr3), .databus(bus3),
        .Read_In(rd3), .Load_Out(lo3), .Load_DIR(ld3), .busy(busy3)
    );

    // Peripheral model: drives IN on a read strobe, loads OUT/DIR on the load strobes
    assign bus  = (rd && addr == 8'h04) ? io_pins : 16'hzzzz;
    assign bus3 = 16'hzzzz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= 16'h0000;
            r_dir  <= 16'h0000;
            r_dir3 <= 16'h0000;
        end else begin
            if (lo && addr == 8'h05) r_out <= bus;
            if (ld && addr == 8'h06) r_dir <= bus;
            if (ld3 && addr3 == 8'h06) r_dir3 <= bus3;
        end
    end

    always @(negedge clk) begin
        if ((int'(rd) + int'(lo) + int'(ld)) > 1 || (int'(rd3) + int'(lo3) + int'(ld3)) > 1)
            overlap = overlap + 1;
        if (ifc.rsp_valid)
            rsp_cnt = rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on dut (SETUP_CYCLES=1): checks every cycle from accept to response
    task automatic txn(input logic w, input logic [1:0] sel, input logic [15:0] wd,
                       input logic exp_err, input logic [15:0] exp_rd,
                       input logic [7:0] exp_addr, input logic [2:0] exp_strb);
        int lat;
        int guard;
        lat = exp_err ? 1 : 3 + HOLD_CYC;
        guard = 0;
        while (!ifc.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", ifc.req_ready, 1);
        ifc.req_valid = 1'b1;
        ifc.req_write = w;
        ifc.req_sel   = sel;
        ifc.req_wdata = wd;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) ifc.req_valid = 1'b0;
            if (k < lat) begin
                check($sformatf("rsp_idle_k%0d", k), ifc.rsp_valid, 0);
                check($sformatf("addr_k%0d", k), addr, exp_addr);
                check($sformatf("strb_k%0d", k), {rd, lo, ld}, (k == 2) ? exp_strb : 3'b000);
                if (k >= 2 && w) check($sformatf("wdata_k%0d", k), bus, wd);
                if (k == 2 && !w) check("rd_bus", bus, io_pins);
            end else begin
                check("rsp_valid", ifc.rsp_valid, 1);
                check("rsp_err", ifc.rsp_err, exp_err);
                check("rsp_rdata", ifc.rsp_rdata, exp_rd);
                check("addr_resp", addr, 8'h00);
                check("strb_resp", {rd, lo, ld}, 3'b000);
            end
        end
        @(negedge clk);
        check("rsp_done", ifc.rsp_valid, 0);
        check("ready_after", ifc.req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        io_pins = 16'h0000;
        ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.req_sel = 2'd0; ifc.req_wdata = 16'h0;
        ifc3.req_valid = 1'b0; ifc3.req_write = 1'b0; ifc3.req_sel = 2'd0; ifc3.req_wdata = 16'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", ifc.req_ready, 1);
        check("rst_rsp_valid", ifc.rsp_valid, 0);
        check("rst_rsp_err", ifc.rsp_err, 0);
        check("rst_rdata", ifc.rsp_rdata, 16'h0000);
        check("rst_addr", addr, 8'h00);
        check("rst_strb", {rd, lo, ld}, 3'b000);
        check("rst_busy", busy1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write OUT, read IN
        txn(1'b1, 2'd1, 16'hA5A5, 1'b0, 16'h0000, 8'h05, 3'b010);
        check("r_out_a5a5", r_out, 16'hA5A5);
        io_pins = 16'h3C0F;
        txn(1'b0, 2'd0, 16'h0000, 1'b0, 16'h3C0F, 8'h04, 3'b100);

        // Illegal requests leave rdata and the peripheral untouched
        txn(1'b1, 2'd0, 16'h1111, 1'b1, 16'h3C0F, 8'h00, 3'b000);
        txn(1'b0, 2'd1, 16'h0000, 1'b1, 16'h3C0F, 8'h00, 3'b000);
        txn(1'b1, 2'd3, 16'h2222, 1'b1, 16'h3C0F, 8'h00, 3'b000);
        txn(1'b0, 2'd3, 16'h0000, 1'b1, 16'h3C0F, 8'h00, 3'b000);
        check("r_out_kept", r_out, 16'hA5A5);

        // Write DIR on the short-setup instance; rdata must survive a write
        txn(1'b1, 2'd2, 16'h0055, 1'b0, 16'h3C0F, 8'h06, 3'b001);
        check("r_dir_0055", r_dir, 16'h0055);

        // Write DIR with SETUP_CYCLES=3
        ifc3.req_valid = 1'b1; ifc3.req_write = 1'b1; ifc3.req_sel = 2'd2; ifc3.req_wdata = 16'h00FF;
        for (int k = 1; k <= 5 + HOLD_CYC; k++) begin
            @(negedge clk);
            if (k == 1) ifc3.req_valid = 1'b0;
            if (k <= 3) begin
                check($sformatf("s3_addr_k%0d", k), addr3, 8'h06);
                check($sformatf("s3_ld_k%0d", k), ld3, 0);
            end else if (k == 4) begin
                check("s3_ld_pulse", {rd3, lo3, ld3}, 3'b001);
                check("s3_bus", bus3, 16'h00FF);
            end
            check($sformatf("s3_rsp_k%0d", k), ifc3.rsp_valid, (k == 5 + HOLD_CYC) ? 1 : 0);
        end
        check("r_dir3_00ff", r_dir3, 16'h00FF);

        // Back-to-back with req_valid held high
        io_pins = 16'h5A5A;
        @(negedge clk);
        ifc.req_valid = 1'b1; ifc.req_write = 1'b1; ifc.req_sel = 2'd1; ifc.req_wdata = 16'h1234;
        for (int k = 1; k <= 3 + HOLD_CYC; k++) @(negedge clk);
        check("b2b_rsp1", ifc.rsp_valid, 1);
        check("b2b_err1", ifc.rsp_err, 0);
        check("b2b_ready_in_resp", ifc.req_ready, 0);
        ifc.req_write = 1'b0; ifc.req_sel = 2'd0;
        @(negedge clk);
        check("b2b_idle_ready", ifc.req_ready, 1);
        check("b2b_idle_busy", busy1, 0);
        check("r_out_1234", r_out, 16'h1234);
        @(negedge clk);
        ifc.req_valid = 1'b0;
        check("b2b_setup_addr", addr, 8'h04);
        @(negedge clk);
        check("b2b_read_strb", {rd, lo, ld}, 3'b100);
        for (int k = 0; k < 1 + HOLD_CYC; k++) @(negedge clk);
        check("b2b_rsp2", ifc.rsp_valid, 1);
        check("b2b_rdata2", ifc.rsp_rdata, 16'h5A5A);
        @(negedge clk);

        // Reset during the STROBE cycle of a write
        ifc.req_valid = 1'b1; ifc.req_write = 1'b1; ifc.req_sel = 2'd1; ifc.req_wdata = 16'h7777;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_lo_before", lo, 1);
        begin
            int snap;
            snap = rsp_cnt;
            #1 rst_n = 1'b0;
            #1;
            check("rst_mid_lo", lo, 0);
            check("rst_mid_addr", addr, 8'h00);
            check("rst_mid_busy", busy1, 0);
            check("rst_mid_ready", ifc.req_ready, 1);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
            check("rst_mid_no_rsp", rsp_cnt, snap);
            check("rst_mid_r_out", r_out, 16'h0000);
        end
        txn(1'b1, 2'd1, 16'hBEEF, 1'b0, 16'h0000, 8'h05, 3'b010);
        check("r_out_beef", r_out, 16'hBEEF);

        check("no_strobe_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
